// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target predictor.
//   bp_state_t  : table controller states (CLEAR sweep, RUN)
//   weak_nt/t   : weakly-not-taken / weakly-taken counter values for a width
//   sat_update  : saturating +1/-1 of a direction counter of a given width
// Helpers work on 32-bit values; callers cast down to the counter width.
package bp_pkg;

   typedef enum logic {
      CLEAR,
      RUN
   } bp_state_t;

   // MSB 0, remaining bits 1
   function automatic logic [31:0] weak_nt(input int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // MSB 1, remaining bits 0
   function automatic logic [31:0] weak_t(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic logic [31:0] sat_update(input logic [31:0] v,
                                              input logic        up,
                                              input int unsigned w);
      logic [31:0] max;
      max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      if (up)
         return (v == max) ? v : v + 32'd1;
      else
         return (v == '0) ? v : v - 32'd1;
   endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down counter.
//   clk   : clock
//   clear : synchronous clear to zero (highest priority)
//   inc   : count up, holds at all-ones
//   dec   : count down, holds at zero (inc and dec together hold)
//   count : current value
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (inc && !dec && (count != '1))
         count <= count + 1'b1;
      else if (dec && !inc && (count != '0))
         count <= count - 1'b1;
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-stage branch predictor: direct-mapped table of tagged entries, each
// with a saturating direction counter and a branch target.
//   clk, rst          : clock, synchronous active-high reset
//   ready             : table initialised (low during the clear sweep)
//   lk_pc             : fetch PC looked up combinationally
//   lk_hit/lk_taken   : valid matching entry / predicted taken
//   lk_next_pc        : predicted next fetch PC
//   upd_*             : resolved conditional branch fed back from decode
//   redirect(_pc)     : mispredict flush and corrected PC
//   branch_cnt        : resolved branches since reset (saturating)
//   mispred_cnt       : mispredicts since reset (saturating)
module branch_target_predictor
   import bp_pkg::*;
#(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CTR_W = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready,
   input  logic [PC_W-1:0]  lk_pc,
   output logic             lk_hit,
   output logic             lk_taken,
   output logic [PC_W-1:0]  lk_next_pc,
   input  logic             upd_valid,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic [PC_W-1:0]  upd_target,
   input  logic             upd_pred_taken,
   input  logic [PC_W-1:0]  upd_pred_target,
   output logic             redirect,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam int unsigned TAG_W = PC_W - IDX_W;
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(weak_nt(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(weak_t(CTR_W));

   bp_state_t        state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;

   logic             tbl_valid  [DEPTH];
   logic [TAG_W-1:0] tbl_tag    [DEPTH];
   logic [CTR_W-1:0] tbl_ctr    [DEPTH];
   logic [PC_W-1:0]  tbl_target [DEPTH];

   // ---------------- controller ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         CLEAR: begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == '1)
               state_nxt = RUN;
         end
         RUN: ;
         default: state_nxt = CLEAR;
      endcase
   end

   assign ready = (state == RUN);

   // ---------------- lookup port ----------------
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   assign lk_idx = lk_pc[IDX_W-1:0];
   assign lk_tag = lk_pc[PC_W-1:IDX_W];

   assign lk_hit     = ready && tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
   assign lk_taken   = lk_hit && tbl_ctr[lk_idx][CTR_W-1];
   assign lk_next_pc = lk_taken ? tbl_target[lk_idx] : lk_pc + 1'b1;

   // ---------------- training / sweep write port ----------------
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   assign up_idx = upd_pc[IDX_W-1:0];
   assign up_tag = upd_pc[PC_W-1:IDX_W];
   assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);

   logic             we;
   logic [IDX_W-1:0] w_idx;
   logic             w_valid;
   logic [TAG_W-1:0] w_tag;
   logic [CTR_W-1:0] w_ctr;
   logic [PC_W-1:0]  w_target;

   // Writes are suppressed in the rst cycle; the sweep that follows
   // rebuilds every entry anyway.
   always_comb begin
      we       = 1'b0;
      w_idx    = ptr;
      w_valid  = 1'b0;
      w_tag    = '0;
      w_ctr    = CTR_WNT;
      w_target = '0;
      if (!rst) begin
         if (state == CLEAR) begin
            we = 1'b1;
         end else if (upd_valid) begin
            we      = 1'b1;
            w_idx   = up_idx;
            w_valid = 1'b1;
            w_tag   = up_tag;
            if (up_hit) begin
               w_ctr    = CTR_W'(sat_update(32'(tbl_ctr[up_idx]), upd_taken, CTR_W));
               w_target = upd_taken ? upd_target : tbl_target[up_idx];
            end else begin
               w_ctr    = upd_taken ? CTR_WT : CTR_WNT;
               w_target = upd_target;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tbl_valid[w_idx]  <= w_valid;
         tbl_tag[w_idx]    <= w_tag;
         tbl_ctr[w_idx]    <= w_ctr;
         tbl_target[w_idx] <= w_target;
      end
   end

   // ---------------- redirect ----------------
   assign redirect = ready && upd_valid &&
                     ((upd_pred_taken != upd_taken) ||
                      (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));
   assign redirect_pc = upd_taken ? upd_target : upd_pc + 1'b1;

   // ---------------- performance counters ----------------
   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (ready && upd_valid),
      .dec   (1'b0),
      .count (branch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_mispred_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (redirect),
      .dec   (1'b0),
      .count (mispred_cnt)
   );

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] lk_pc;
   logic       upd_valid;
   logic [7:0] upd_pc;
   logic       upd_taken;
   logic [7:0] upd_target;
   logic       upd_pred_taken;
   logic [7:0] upd_pred_target;

   logic        ready, lk_hit, lk_taken, redirect;
   logic [7:0]  lk_next_pc, redirect_pc;
   logic [15:0] branch_cnt, mispred_cnt;

   logic        ready2, lk_hit2, lk_taken2, redirect2;
   logic [7:0]  lk_next_pc2, redirect_pc2;
   logic [1:0]  branch_cnt2, mispred_cnt2;

   always #5 clk = ~clk;

   branch_target_predictor #(.PC_W(8), .IDX_W(4), .CTR_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_next_pc(lk_next_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_target_predictor #(.PC_W(8), .IDX_W(4), .CTR_W(2), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .ready(ready2),
      .lk_pc(lk_pc), .lk_hit(lk_hit2), .lk_taken(lk_taken2), .lk_next_pc(lk_next_pc2),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .redirect(redirect2), .redirect_pc(redirect_pc2),
      .branch_cnt(branch_cnt2), .mispred_cnt(mispred_cnt2)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: 16 entries, counters as plain integers 0..3.
   bit m_valid  [16];
   int m_tag    [16];
   int m_ctr    [16];
   int m_target [16];
   int m_clear_left = 16;
   int m_bcnt = 0, m_mcnt = 0, m_bcnt2 = 0;
   bit m_armed = 0;

   function automatic bit m_hit(input int pc);
      return (m_clear_left == 0) && m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
   endfunction

   function automatic bit m_taken(input int pc);
      return m_hit(pc) && (m_ctr[pc % 16] >= 2);
   endfunction

   function automatic int m_next(input int pc);
      return m_taken(pc) ? m_target[pc % 16] : (pc + 1) % 256;
   endfunction

   task automatic cycle(input bit r, input bit uv, input int upc, input bit ut,
                        input int utgt, input bit upt, input int uptgt, input int lkpc);
      bit exp_redir;
      int idx;
      rst             = r;
      upd_valid       = uv;
      upd_pc          = 8'(upc);
      upd_taken       = ut;
      upd_target      = 8'(utgt);
      upd_pred_taken  = upt;
      upd_pred_target = 8'(uptgt);
      lk_pc           = 8'(lkpc);
      #1;
      exp_redir = (m_clear_left == 0) && uv &&
                  ((upt != ut) || (ut && upt && (uptgt != utgt)));
      if (m_armed) begin
         chk("ready",       32'(ready),       32'(m_clear_left == 0));
         chk("lk_hit",      32'(lk_hit),      32'(m_hit(lkpc)));
         chk("lk_taken",    32'(lk_taken),    32'(m_taken(lkpc)));
         chk("lk_next_pc",  32'(lk_next_pc),  32'(m_next(lkpc)));
         chk("redirect",    32'(redirect),    32'(exp_redir));
         if (uv)
            chk("redirect_pc", 32'(redirect_pc), ut ? 32'(utgt) : 32'((upc + 1) % 256));
         chk("branch_cnt",  32'(branch_cnt),  32'(m_bcnt));
         chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
         chk("branch_cnt2", 32'(branch_cnt2), 32'(m_bcnt2));
      end
      @(posedge clk);
      if (r) begin
         m_clear_left = 16;
         for (int i = 0; i < 16; i++) m_valid[i] = 0;
         m_bcnt = 0; m_mcnt = 0; m_bcnt2 = 0;
         m_armed = 1;
      end else if (m_clear_left > 0) begin
         m_clear_left--;
      end else if (uv) begin
         if (m_bcnt  < 65535) m_bcnt++;
         if (m_bcnt2 < 3)     m_bcnt2++;
         if (exp_redir && m_mcnt < 65535) m_mcnt++;
         idx = upc % 16;
         if (m_valid[idx] && m_tag[idx] == upc / 16) begin
            m_ctr[idx] = ut ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                            : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
            if (ut) m_target[idx] = utgt;
         end else begin
            m_valid[idx]  = 1;
            m_tag[idx]    = upc / 16;
            m_target[idx] = utgt;
            m_ctr[idx]    = ut ? 2 : 1;
         end
      end
      #1;
   endtask

   task automatic idle(input int lkpc);
      cycle(0, 0, 0, 0, 0, 0, 0, lkpc);
   endtask

   // Update carrying the model's own fetch-time prediction.
   task automatic train(input int pc, input bit t, input int tgt, input int lkpc);
      cycle(0, 1, pc, t, tgt, m_taken(pc), m_next(pc), lkpc);
   endtask

   initial begin
      cycle(1, 0, 0, 0, 0, 0, 0, 8'h05);
      // CLEAR sweep, with updates offered that must be ignored
      for (int i = 0; i < 16; i++)
         cycle(0, i % 2, 8'h13, 1, 8'h40, 0, 8'h14, 8'h05);
      chk("ready_17th", 32'(ready), 32'd1);
      idle(8'h05);

      // first training: mispredicted taken
      cycle(0, 1, 8'h13, 1, 8'h40, 0, 8'h14, 8'h05);
      idle(8'h13);
      for (int i = 0; i < 3; i++) train(8'h13, 0, 8'h00, 8'h13);
      idle(8'h13);
      train(8'h13, 1, 8'h40, 8'h13);
      idle(8'h13);

      // aliasing on index 3
      idle(8'h23);
      train(8'h23, 1, 8'h77, 8'h23);
      idle(8'h13);
      idle(8'h23);

      // same-cycle lookup and update
      train(8'h13, 1, 8'h55, 8'h13);
      train(8'h13, 1, 8'h66, 8'h13);
      idle(8'h13);
      idle(8'hFF);

      // reset restarted mid-sweep
      cycle(1, 0, 0, 0, 0, 0, 0, 8'h13);
      for (int i = 0; i < 8; i++) cycle(0, 1, 8'h13, 1, 8'h40, 0, 8'h14, 8'h13);
      cycle(1, 0, 0, 0, 0, 0, 0, 8'h13);
      for (int i = 0; i < 16; i++) cycle(0, 1, 8'h13, 1, 8'h40, 0, 8'h14, 8'h13);
      chk("ready_after_restart", 32'(ready), 32'd1);

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         int pc, tgt, lk;
         bit t, pt, r;
         int ptgt;
         r   = ($urandom_range(0, 149) == 0);
         pc  = ($urandom_range(0, 99) < 85) ? (($urandom_range(0, 3) << 4) | $urandom_range(0, 3))
                                             : $urandom_range(0, 255);
         t   = $urandom_range(0, 1);
         tgt = $urandom_range(0, 255);
         pt   = m_taken(pc);
         ptgt = m_next(pc);
         case ($urandom_range(0, 7))
            0: pt = ~pt;
            1: ptgt = $urandom_range(0, 255);
            default: ;
         endcase
         lk = $urandom_range(0, 1) ? pc : $urandom_range(0, 255);
         cycle(r, $urandom_range(0, 1), pc, t, tgt, pt, ptgt, lk);
      end

      // small-counter saturation: 5 branches on CNT_W=2 reads 3
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) idle(0);
      for (int i = 0; i < 5; i++) train(8'h40 + i, 1, 8'h10, 8'h00);
      chk("branch_cnt2_sat", 32'(branch_cnt2), 32'd3);
      chk("branch_cnt_5",    32'(branch_cnt),  32'd5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
